// File: rtl/audio_rate_buffer.sv
// Elastic PCM sample FIFO: bursty writes in, fixed-rate pops out to the DAC as 12-bit offset binary.
// Optional round-to-nearest conversion is enabled with `define AUDIO_ROUNDING_EN.
module audio_rate_buffer #(
  parameter int clock_max   = 25_000_000,
  parameter int sample_rate = 400,
  parameter int DEPTH       = 16
) (
  input  logic                    clk_25mhz,
  input  logic                    reset,
  input  logic                    data_ready,
  input  logic [15:0]             audio_in,
  input  logic                    dac_ready,
  output logic [11:0]             sample_out,
  output logic                    sample_valid,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow,
  output logic                    underflow
);
  localparam int PERIOD = clock_max / sample_rate;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;

  typedef enum logic {FILL, PLAY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   tick_cnt;
  logic            tick;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            pending_q, pending_d;
  logic            empty, full, push, pop, starve;

  function automatic logic [11:0] to_dac(input logic [15:0] s);
    logic [15:0] r;
`ifdef AUDIO_ROUNDING_EN
    r = ($signed(s) > 16'sh7FF7) ? 16'h7FFF : s + 16'd8;
`else
    r = s;
`endif
    return {~r[15], r[14:4]};
  endfunction

  assign tick  = (tick_cnt == CW'(PERIOD - 1));
  assign empty = (fifo_level == '0);
  assign full  = (fifo_level == LW'(DEPTH));
  // pop is resolved first, so a write at full still lands when a pop frees a slot
  assign push  = data_ready && (!full || pop);

  always_ff @(posedge clk_25mhz) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + CW'(1);
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    pop       = 1'b0;
    starve    = 1'b0;
    case (state_q)
      FILL: begin
        pending_d = 1'b0;
        if (fifo_level >= LW'(DEPTH / 2)) state_d = PLAY;
      end
      PLAY: begin
        if (pending_q && dac_ready) begin
          pending_d = 1'b0;
          if (!empty) begin
            pop = 1'b1;
          end else begin
            starve  = 1'b1;
            state_d = FILL;
          end
        end else if (tick) begin
          pending_d = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (push) mem[wr_ptr] <= audio_in;
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state_q      <= FILL;
      pending_q    <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      sample_out   <= 12'h800;
      sample_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      sample_valid <= pop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        sample_out <= to_dac(mem[rd_ptr]);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (data_ready && !push) overflow  <= 1'b1;
      if (starve)              underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_rate_buffer.sv
// Scoreboard bench for audio_rate_buffer: PERIOD=10, DEPTH=16.
module tb_audio_rate_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_ready = 1'b0;
  logic [15:0] audio_in = '0;
  logic        dac_ready = 1'b0;
  logic [11:0] sample_out;
  logic        sample_valid;
  logic [4:0]  fifo_level;
  logic        overflow, underflow;

  int vectors = 0, miscompares = 0, pops = 0, cyc = 0;
  logic [11:0] exp_q[$];
  int          pop_time[$];
  logic [11:0] mon_exp;

  logic [15:0] cv_in  [8] = '{16'h7FFF, 16'h0000, 16'h8000, 16'h0008,
                             16'h7FFC, 16'hFFF8, 16'h7FF8, 16'h1230};
`ifdef AUDIO_ROUNDING_EN
  logic [11:0] cv_exp [8] = '{12'hFFF, 12'h800, 12'h000, 12'h801,
                             12'hFFF, 12'h800, 12'hFFF, 12'h923};
`else
  logic [11:0] cv_exp [8] = '{12'hFFF, 12'h800, 12'h000, 12'h800,
                             12'hFFF, 12'h7FF, 12'hFFF, 12'h923};
`endif

  audio_rate_buffer #(.clock_max(1000), .sample_rate(100), .DEPTH(16)) dut (
    .clk_25mhz(clk), .reset(reset), .data_ready(data_ready), .audio_in(audio_in),
    .dac_ready(dac_ready), .sample_out(sample_out), .sample_valid(sample_valid),
    .fifo_level(fifo_level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // arithmetic reference: shift signed range to 0..65535, keep top 12 bits
  function automatic logic [11:0] model(input logic [15:0] s);
    int v;
    v = $signed(s);
`ifdef AUDIO_ROUNDING_EN
    v = v + 8;
    if (v > 32767) v = 32767;
`endif
    v = (v + 32768) >>> 4;
    return v[11:0];
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (sample_valid === 1'b1) begin
      vectors++;
      pops++;
      pop_time.push_back(cyc);
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: sample_out=%h but no sample queued", sample_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (sample_out !== mon_exp) begin
          miscompares++;
          $display("FAIL scoreboard: sample_out=%h expected %h", sample_out, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    data_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
    pop_time.delete();
    pops = 0;
  endtask

  task automatic write_sample(input logic [15:0] v, input bit accept);
    data_ready = 1'b1;
    audio_in = v;
    if (accept) exp_q.push_back(model(v));
    step();
    data_ready = 1'b0;
  endtask

  task automatic wait_pops(input int target, input int budget, input string name);
    int n = 0;
    while (pops < target && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (pops < target) begin
      miscompares++;
      $display("FAIL %s_timeout: pops=%0d required %0d", name, pops, target);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors += 4;
    if (sample_out !== 12'h800) begin miscompares++; $display("FAIL reset_out: %h expected 800", sample_out); end
    if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL reset_level: %0d expected 0", fifo_level); end
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: %b expected 0", overflow); end
    if (underflow !== 1'b0) begin miscompares++; $display("FAIL reset_unf: %b expected 0", underflow); end
    repeat (100) step();
    vectors++;
    if (pops !== 0) begin miscompares++; $display("FAIL reset_idle: pops=%0d expected 0", pops); end
  endtask

  task automatic test_prebuffer();
    logic [15:0] v [8] = '{16'h1230, 16'h8000, 16'h0100, 16'hFF00,
                          16'h4000, 16'hC000, 16'h0010, 16'h7FFF};
    do_reset();
    dac_ready = 1'b1;
    for (int i = 0; i < 7; i++) write_sample(v[i], 1'b1);
    repeat (25) step();
    vectors += 2;
    if (pops !== 0) begin miscompares++; $display("FAIL prebuf_early: pops=%0d expected 0", pops); end
    if (fifo_level !== 5'd7) begin miscompares++; $display("FAIL prebuf_level: %0d expected 7", fifo_level); end
    write_sample(v[7], 1'b1);
    wait_pops(1, 25, "prebuf_first");
    vectors++;
    if (sample_out !== 12'h923) begin miscompares++; $display("FAIL prebuf_s0: %h expected 923", sample_out); end
    wait_pops(2, 15, "prebuf_second");
    vectors++;
    if (sample_out !== 12'h000) begin miscompares++; $display("FAIL prebuf_s1: %h expected 000", sample_out); end
  endtask

  task automatic test_overflow();
    do_reset();
    dac_ready = 1'b0;
    for (int i = 0; i < 16; i++) write_sample(16'(i * 16'h0911 + 16'h0040), 1'b1);
    step();
    vectors += 2;
    if (fifo_level !== 5'd16) begin miscompares++; $display("FAIL ovf_full_level: %0d expected 16", fifo_level); end
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early: %b expected 0", overflow); end
    write_sample(16'hABCD, 1'b0);
    step();
    vectors += 3;
    if (fifo_level !== 5'd16) begin miscompares++; $display("FAIL ovf_level: %0d expected 16", fifo_level); end
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: %b expected 1", overflow); end
    if (underflow !== 1'b0) begin miscompares++; $display("FAIL ovf_unf: %b expected 0", underflow); end
    dac_ready = 1'b1;
    wait_pops(16, 200, "ovf_drain");
    repeat (15) step();
    vectors += 2;
    if (pops !== 16) begin miscompares++; $display("FAIL ovf_pops: %0d expected 16", pops); end
    if (underflow !== 1'b1) begin miscompares++; $display("FAIL ovf_drain_unf: %b expected 1", underflow); end
  endtask

  task automatic test_underflow();
    logic [15:0] last = 16'h2468;
    do_reset();
    dac_ready = 1'b1;
    for (int i = 0; i < 7; i++) write_sample(16'(16'h1111 * i), 1'b1);
    write_sample(last, 1'b1);
    wait_pops(8, 150, "unf_drain");
    vectors++;
    if (underflow !== 1'b0) begin miscompares++; $display("FAIL unf_early: %b expected 0", underflow); end
    for (int i = 1; i < 8 && i < pop_time.size(); i++) begin
      vectors++;
      if (pop_time[i] - pop_time[i-1] !== 10) begin
        miscompares++;
        $display("FAIL unf_spacing: gap %0d is %0d cycles expected 10", i, pop_time[i] - pop_time[i-1]);
      end
    end
    repeat (15) step();
    vectors += 3;
    if (underflow !== 1'b1) begin miscompares++; $display("FAIL unf_flag: %b expected 1", underflow); end
    if (sample_out !== model(last)) begin miscompares++; $display("FAIL unf_hold: %h expected %h", sample_out, model(last)); end
    if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL unf_level: %0d expected 0", fifo_level); end
    for (int i = 0; i < 7; i++) write_sample(16'h0500, 1'b1);
    repeat (30) step();
    vectors++;
    if (pops !== 8) begin miscompares++; $display("FAIL unf_refill: pops=%0d expected 8", pops); end
  endtask

  task automatic test_backpressure();
    do_reset();
    dac_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_sample(16'(16'h0F00 + i), 1'b1);
    repeat (35) step();
    vectors += 2;
    if (pops !== 0) begin miscompares++; $display("FAIL bp_stall: pops=%0d expected 0", pops); end
    if (fifo_level !== 5'd8) begin miscompares++; $display("FAIL bp_level0: %0d expected 8", fifo_level); end
    dac_ready = 1'b1;
    step();
    step();
    dac_ready = 1'b0;
    repeat (5) step();
    vectors += 2;
    if (pops !== 1) begin miscompares++; $display("FAIL bp_single: pops=%0d expected 1", pops); end
    if (fifo_level !== 5'd7) begin miscompares++; $display("FAIL bp_level1: %0d expected 7", fifo_level); end
  endtask

  task automatic test_reset_mid_play();
    do_reset();
    dac_ready = 1'b0;
    write_sample(16'h1230, 1'b1);
    for (int i = 1; i < 11; i++) write_sample(16'(16'h0300 * i), 1'b1);
    repeat (15) step();
    dac_ready = 1'b1;
    step();
    step();
    dac_ready = 1'b0;
    repeat (3) step();
    vectors += 3;
    if (pops !== 1) begin miscompares++; $display("FAIL mid_pop: pops=%0d expected 1", pops); end
    if (sample_out !== 12'h923) begin miscompares++; $display("FAIL mid_out: %h expected 923", sample_out); end
    if (fifo_level !== 5'd10) begin miscompares++; $display("FAIL mid_level: %0d expected 10", fifo_level); end
    do_reset();
    vectors += 3;
    if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL mid_rst_level: %0d expected 0", fifo_level); end
    if (sample_out !== 12'h800) begin miscompares++; $display("FAIL mid_rst_out: %h expected 800", sample_out); end
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      miscompares++; $display("FAIL mid_rst_flags: ovf=%b unf=%b expected 0 0", overflow, underflow);
    end
    dac_ready = 1'b1;
    for (int i = 0; i < 7; i++) write_sample(16'h0700, 1'b1);
    repeat (30) step();
    vectors++;
    if (pops !== 0) begin miscompares++; $display("FAIL mid_rst_fill: pops=%0d expected 0", pops); end
  endtask

  task automatic test_convert();
    do_reset();
    dac_ready = 1'b1;
    for (int i = 0; i < 8; i++) write_sample(cv_in[i], 1'b1);
    for (int k = 0; k < 8; k++) begin
      wait_pops(k + 1, 30, "conv");
      vectors++;
      if (sample_out !== cv_exp[k]) begin
        miscompares++;
        $display("FAIL conv_%h: %h expected %h", cv_in[k], sample_out, cv_exp[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_prebuffer();
    test_overflow();
    test_underflow();
    test_backpressure();
    test_reset_mid_play();
    test_convert();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
